semi_auto_executor: RTL
=======================

Name: semi_auto_executor

Overview:
- Responder side of the semi-auto trigger handshake. Executes one manoeuvre per request: an optional timed turn, then forward motion until the next junction.
- Sits between the auto-mode decision FSM (the initiator, which raises triggers) and the car motion outputs.
- Reports progress on a 3-bit state code; the initiator holds its trigger until the code leaves WAITING, then waits for WAITING to return.

Parameters:
- TURN_TIME, 450: cycles per 90-degree turn (2 ms clock, 0.9 s).
- LEAVE_TIME, 250: cycles of blind forward motion after a turn, so the car clears the current junction.
- MOVE_TIMEOUT, 5000: MOVING watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, 2 ms tick.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  block enable; low forces DISABLED.
- move_forward  in  1  request: go straight.
- move_left  in  1  request: turn left, then go.
- move_right  in  1  request: turn right, then go.
- move_backward  in  1  request: U-turn, then go.
- detector  in  4  obstacle flags, 1 = blocked; [3] front, [2] back, [1] left, [0] right.
- out_move_forward  out  1  drive forward.
- turn_left  out  1  rotate left in place.
- turn_right  out  1  rotate right in place.
- out_state  out  3  current state code.
- timeout_flag  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous and active-low, rst_n; all state updates on posedge clk.
- Priority per edge: rst_n=0 wins; otherwise enable=0 forces DISABLED.
- After reset or disable: state DISABLED; all outputs 0; counter 0.
- Moore outputs, decoded from state only.
- State codes:
  - DISABLED 000: no outputs.
  - WAITING 001: no outputs.
  - TURN_L 010: turn_left=1.
  - TURN_R 011: turn_right=1.
  - TURN_B 100: turn_right=1.
  - LEAVING 110: out_move_forward=1.
  - MOVING 101: out_move_forward=1.
- DISABLED -> WAITING on the first edge with enable=1.
- WAITING: samples the triggers every edge; first cycle with any trigger high moves to the new state on the next edge.
  - Priority: forward > left > right > backward.
  - forward -> LEAVING; left -> TURN_L; right -> TURN_R; backward -> TURN_B.
  - Triggers are ignored in every state other than WAITING. A held trigger never re-fires until WAITING is re-entered.
- 32-bit counter:
  - Cleared on every state change; increments each cycle the state is unchanged.
- TURN_L / TURN_R: leave to LEAVING when counter == TURN_TIME-1, so the turn output is high exactly TURN_TIME cycles.
- TURN_B: same rule with limit 2*TURN_TIME-1. Detector is ignored during all turns.
- LEAVING: go to MOVING when counter == LEAVE_TIME-1. Detector is ignored.
- MOVING: stays while detector[3]==0 && detector[1]==1 && detector[0]==1.
  - Front blocked, or either side open, -> WAITING on the next edge.
  - The transition is taken even if the condition holds for only one cycle.
- Simultaneous events:
  - enable falling mid-manoeuvre aborts immediately to DISABLED; outputs drop the following cycle.
  - Re-enable restarts from WAITING; no resume.
- Reset mid-operation: identical to power-up.
- At most one of turn_left / turn_right / out_move_forward is high in any cycle.

Optional Feature:
- Macro: SEMI_MOVE_TIMEOUT_EN.
- Defined: in MOVING, when counter == MOVE_TIMEOUT-1 the block forces WAITING. timeout_flag pulses high for exactly the first cycle of that WAITING.
- Not defined: no watchdog; MOVING exits only on the detector condition; timeout_flag tied to 0.

Test Plan (TURN_TIME=4, LEAVE_TIME=3, MOVE_TIMEOUT=10):
- Reset and enable:
  - rst_n=0 for 2 cycles with enable=1 -> out_state=000 and all outputs 0.
  - Release rst_n -> out_state=001 on the next edge.
- Right turn:
  - move_right=1 in WAITING with detector=4'b0011 -> out_state=011 and turn_right=1 for exactly 4 cycles.
  - Then out_state=110 with out_move_forward=1 for 3 cycles, then out_state=101.
  - Set detector=4'b0010 -> out_state=001 on the next edge, outputs 0.
- Priority and U-turn:
  - move_forward=1 and move_left=1 together -> out_state=110, turn_left never high.
  - move_backward=1 alone -> turn_right=1 for exactly 8 cycles.
- Front block: in MOVING with detector=4'b0011, set detector=4'b1011 -> WAITING next edge.
- Abort:
  - enable=0 at turn cycle 2 -> out_state=000 and turn_left=0 the next cycle.
  - enable=1 -> 001; a held move_left=1 then fires a fresh full 4-cycle turn.
- Watchdog (macro on): hold detector=4'b0011 in MOVING -> WAITING after 10 cycles, timeout_flag=1 for one cycle. With macro off, still MOVING after 20 cycles and timeout_flag stays 0.

Source files
------------

// File: rtl/semi_auto_executor_if.sv
// Trigger/status bundle between the auto-mode initiator and the semi-auto executor.
// The initiator drives enable, triggers and detector flags; the executor drives motion and state.
interface semi_auto_executor_if;
    logic       enable;
    logic       move_forward;
    logic       move_left;
    logic       move_right;
    logic       move_backward;
    logic [3:0] detector;
    logic       out_move_forward;
    logic       turn_left;
    logic       turn_right;
    logic [2:0] out_state;
    logic       timeout_flag;

    modport master (
        output enable, move_forward, move_left, move_right, move_backward, detector,
        input  out_move_forward, turn_left, turn_right, out_state, timeout_flag
    );

    modport slave (
        input  enable, move_forward, move_left, move_right, move_backward, detector,
        output out_move_forward, turn_left, turn_right, out_state, timeout_flag
    );
endinterface

// File: rtl/semi_auto_executor.sv
// Semi-auto manoeuvre executor: optional timed turn, blind junction exit, then forward until a junction.
// Optional MOVING watchdog enabled by defining SEMI_MOVE_TIMEOUT_EN.
module semi_auto_executor #(
    parameter int unsigned TURN_TIME    = 450,
    parameter int unsigned LEAVE_TIME   = 250,
    parameter int unsigned MOVE_TIMEOUT = 5000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    semi_auto_executor_if.slave      bus
);

    typedef enum logic [2:0] {
        DISABLED = 3'b000,
        WAITING  = 3'b001,
        TURN_L   = 3'b010,
        TURN_R   = 3'b011,
        TURN_B   = 3'b100,
        MOVING   = 3'b101,
        LEAVING  = 3'b110
    } state_t;

    if (TURN_TIME == 0 || LEAVE_TIME == 0 || MOVE_TIMEOUT == 0) begin : g_param_check
        $error("semi_auto_executor: TURN_TIME, LEAVE_TIME and MOVE_TIMEOUT must be non-zero");
    end

    localparam logic [31:0] TURN_LIMIT  = 32'(TURN_TIME - 1);
    localparam logic [31:0] UTURN_LIMIT = 32'(2 * TURN_TIME - 1);
    localparam logic [31:0] LEAVE_LIMIT = 32'(LEAVE_TIME - 1);

    state_t      state_reg, state_next;
    logic [31:0] count_reg, count_next;
    logic        path_open;

    // The rear sensor plays no part in any decision.
    logic unused_back;
    assign unused_back = bus.detector[2];

    // Corridor continues only while the front is clear and both sides are walled.
    assign path_open = !bus.detector[3] && bus.detector[1] && bus.detector[0];

`ifdef SEMI_MOVE_TIMEOUT_EN
    localparam logic [31:0] MOVE_LIMIT = 32'(MOVE_TIMEOUT - 1);
    logic timeout_reg, timeout_next;
`endif

    always_comb begin
        state_next = state_reg;
`ifdef SEMI_MOVE_TIMEOUT_EN
        timeout_next = 1'b0;
`endif
        if (!bus.enable) begin
            state_next = DISABLED;
        end else begin
            case (state_reg)
                DISABLED: state_next = WAITING;
                WAITING: begin
                    if (bus.move_forward)       state_next = LEAVING;
                    else if (bus.move_left)     state_next = TURN_L;
                    else if (bus.move_right)    state_next = TURN_R;
                    else if (bus.move_backward) state_next = TURN_B;
                end
                TURN_L, TURN_R: begin
                    if (count_reg == TURN_LIMIT) state_next = LEAVING;
                end
                TURN_B: begin
                    if (count_reg == UTURN_LIMIT) state_next = LEAVING;
                end
                LEAVING: begin
                    if (count_reg == LEAVE_LIMIT) state_next = MOVING;
                end
                MOVING: begin
`ifdef SEMI_MOVE_TIMEOUT_EN
                    if (count_reg == MOVE_LIMIT) begin
                        state_next   = WAITING;
                        timeout_next = 1'b1;
                    end
`endif
                    if (!path_open) state_next = WAITING;
                end
                default: state_next = DISABLED;
            endcase
        end
    end

    // Counter measures time spent in the current state; held at zero while disabled.
    always_comb begin
        count_next = count_reg + 32'd1;
        if (!bus.enable || (state_next != state_reg)) count_next = 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= DISABLED;
            count_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

`ifdef SEMI_MOVE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) timeout_reg <= 1'b0;
        else        timeout_reg <= timeout_next;
    end
    assign bus.timeout_flag = timeout_reg;
`else
    assign bus.timeout_flag = 1'b0;
`endif

    assign bus.out_state        = state_reg;
    assign bus.turn_left        = (state_reg == TURN_L);
    assign bus.turn_right       = (state_reg == TURN_R) || (state_reg == TURN_B);
    assign bus.out_move_forward = (state_reg == LEAVING) || (state_reg == MOVING);

endmodule
